// File: rtl/plic_target_ctrl_if.sv
// Claim/complete handshake between the PLIC register file and one target
// controller. The register file is the master; the target controller is the slave.
interface plic_target_ctrl_if #(
  parameter int IdWidth = 5
);
  logic               claim_i;
  logic [IdWidth-1:0] claim_id_o;
  logic               complete_i;
  logic [IdWidth-1:0] complete_id_i;
  logic               irq_o;
  logic [IdWidth-1:0] irq_id_o;

  modport master (
    output claim_i,
    output complete_i,
    output complete_id_i,
    input  claim_id_o,
    input  irq_o,
    input  irq_id_o
  );

  modport slave (
    input  claim_i,
    input  complete_i,
    input  complete_id_i,
    output claim_id_o,
    output irq_o,
    output irq_id_o
  );
endinterface

// File: rtl/plic_target_ctrl.sv
// Per-target PLIC controller: interrupt gateways for every source,
// priority/threshold arbitration and the claim/complete handshake.
// Arbitration works on the next-state pending vector and is registered, so
// a claim in cycle t presents the next winner from cycle t+1.
module plic_target_ctrl #(
  parameter int NumSources  = 30,
  parameter int MaxPriority = 7,
  parameter int PrioWidth   = $clog2(MaxPriority + 1),
  parameter int IdWidth     = $clog2(NumSources + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumSources-1:0]                irq_src_i,
  input  logic [NumSources-1:0]                edge_i,
  input  logic [NumSources-1:0][PrioWidth-1:0] prio_i,
  input  logic [NumSources-1:0]                ie_i,
  input  logic [PrioWidth-1:0]                 threshold_i,
  output logic [NumSources-1:0]                pending_o,
  plic_target_ctrl_if.slave                    bus
);

  logic [NumSources-1:0] pending_q, pending_d;
  logic [NumSources-1:0] in_service_q, in_service_d;
  logic [NumSources-1:0] deferred_q, deferred_d;
  logic [NumSources-1:0] src_q;
  logic [IdWidth-1:0]    irq_id_q, irq_id_d;
  logic                  irq_q, irq_d;

  logic [NumSources-1:0] rise;
  logic [NumSources-1:0] claim_hit;
  logic [NumSources-1:0] complete_hit;
  logic [NumSources-1:0] busy;
  logic [PrioWidth-1:0]  best_prio;

  assign rise = irq_src_i & ~src_q;

  // Decode the claim and complete strobes into one-hot per-source hits.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    claim_hit    = '0;
    complete_hit = '0;
    for (int k = 0; k < NumSources; k++) begin
      claim_hit[k]    = bus.claim_i && (irq_id_q == IdWidth'(k + 1));
      complete_hit[k] = bus.complete_i && in_service_q[k] &&
                        (bus.complete_id_i == IdWidth'(k + 1));
    end
  end

  // Gateway next state: pending, in-service and deferred bits per source.
  always_comb begin
    // A source is busy if it stays in service through this cycle or is
    // being claimed right now; edges seen while busy go to deferred.
    busy         = (in_service_q & ~complete_hit) | claim_hit;
    in_service_d = busy;
    deferred_d   = (deferred_q & ~complete_hit) | (edge_i & rise & busy);
    pending_d    = (pending_q & ~claim_hit)
                 // Level re-pend waits for in_service to actually clear,
                 // so a completed level source re-pends one cycle later.
                 | (~edge_i & irq_src_i & ~in_service_q & ~claim_hit)
                 | (edge_i & rise & ~busy)
                 | (complete_hit & deferred_q);
  end

  // Pick the highest-priority enabled pending source; ties to lowest ID.
  always_comb begin
    best_prio = '0;
    irq_id_d  = '0;
    for (int k = 0; k < NumSources; k++) begin
      // Strict compare against a zero start excludes priority 0 and keeps
      // the lowest ID on ties.
      if (pending_d[k] && ie_i[k] && (prio_i[k] > best_prio)) begin
        best_prio = prio_i[k];
        irq_id_d  = IdWidth'(k + 1);
      end
    end
    irq_d = (best_prio > threshold_i);
  end

  // Register gateway state and the arbitration result; synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: every state bit is reset here -- a reset must drop all
      // pending, in-service and deferred state, and src_q = 0 makes a line
      // already high at release count as a rising edge.
      pending_q    <= '0;
      in_service_q <= '0;
      deferred_q   <= '0;
      src_q        <= '0;
      irq_id_q     <= '0;
      irq_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values from before this edge, independent of statement order.
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      deferred_q   <= deferred_d;
      src_q        <= irq_src_i;
      irq_id_q     <= irq_id_d;
      irq_q        <= irq_d;
    end
  end

  assign pending_o      = pending_q;
  assign bus.irq_o      = irq_q;
  assign bus.irq_id_o   = irq_id_q;
  assign bus.claim_id_o = bus.claim_i ? irq_id_q : '0;

endmodule
